// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, the NOP word and the PC increment helper.
package if_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_SKID  = 2'd1,
        ST_DROP  = 2'd2
    } if_state_e;

    // Sequential PC increment; the 32-bit result wraps naturally past 32'hFFFF_FFFC.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with clear (bubble) and hold controls.
// Priority: clear over hold over load.
module if_id_reg
    import if_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               hold_i,
    input  logic               load_i,
    input  logic [31:0]        pc4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [31:0]        pc4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [31:0]        r_pc4;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;

    // IF/ID contents: bubble on clear, new word on unheld load, otherwise keep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc4   <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (clear_i) begin
            r_pc4   <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (load_i && !hold_i) begin
            r_pc4   <= pc4_i;
            r_instr <= instr_i;
            r_valid <= 1'b1;
        end
    end

    assign pc4_o   = r_pc4;
    assign instr_o = r_instr;
    assign valid_o = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM (FETCH/SKID/DROP), skid buffer
// and pending-redirect target, feeding the IF/ID register.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [31:0]        pc_o,
    output logic [31:0]        ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o
);

    if_state_e          r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_pending;
    logic [31:0]        r_skid_pc4;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               r_req;

    if_state_e          w_next_state;
    logic [31:0]        w_next_pc;
    logic [31:0]        w_next_pending;
    logic [31:0]        w_pc4;
    logic               w_skid_load;
    logic               w_ifid_load;
    logic [31:0]        w_ifid_pc4;
    logic [INSTR_W-1:0] w_ifid_instr;

    assign w_pc4 = pc_plus4(r_pc);

    // Next-state, next-PC and IF/ID load decisions.
    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_pending = r_pending;
        w_skid_load    = 1'b0;
        w_ifid_load    = 1'b0;
        w_ifid_pc4     = w_pc4;
        w_ifid_instr   = imem_data_i;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    if (redirect_i) begin
                        w_next_pc = redirect_pc_i;
                    end else if (stall_i) begin
                        w_next_pc = w_pc4;
                        // A flush also throws away the word that would have been parked.
                        if (!flush_i) begin
                            w_skid_load  = 1'b1;
                            w_next_state = ST_SKID;
                        end else begin
                            w_next_state = ST_FETCH;
                        end
                    end else begin
                        w_next_pc   = w_pc4;
                        w_ifid_load = 1'b1;
                    end
                end else if (redirect_i) begin
                    w_next_pending = redirect_pc_i;
                    w_next_state   = ST_DROP;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_SKID: begin
                w_ifid_pc4   = r_skid_pc4;
                w_ifid_instr = r_skid_instr;
                if (redirect_i) begin
                    w_next_pc    = redirect_pc_i;
                    w_next_state = ST_FETCH;
                end else if (flush_i) begin
                    w_next_state = ST_FETCH;
                end else if (!stall_i) begin
                    w_ifid_load  = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_SKID;
                end
            end
            ST_DROP: begin
                if (redirect_i) begin
                    w_next_pending = redirect_pc_i;
                end else begin
                    w_next_pending = r_pending;
                end
                if (imem_ready_i) begin
                    w_next_pc    = redirect_i ? redirect_pc_i : r_pending;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_DROP;
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // FSM state, PC, pending target and registered request strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_pending <= 32'h0000_0000;
            r_req     <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_pending <= w_next_pending;
            r_req     <= (w_next_state != ST_SKID);
        end
    end

    // Skid buffer: parks a word returned while the pipeline is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_skid_pc4   <= 32'h0000_0000;
            r_skid_instr <= NOP_INSTR;
        end else if (w_skid_load) begin
            r_skid_pc4   <= w_pc4;
            r_skid_instr <= imem_data_i;
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .hold_i  (stall_i),
        .load_i  (w_ifid_load),
        .pc4_i   (w_ifid_pc4),
        .instr_i (w_ifid_instr),
        .pc4_o   (ifid_pc4_o),
        .instr_o (ifid_instr_o),
        .valid_o (ifid_valid_o)
    );

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_pc;
    assign pc_o        = r_pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational instruction memory whose
// word is a fixed function of the address; expected values are hand-derived.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = word_at(imem_addr);

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_data_i   (imem_data),
        .pc_o          (pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr),
        .ifid_valid_o  (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] p4,
                              input logic [31:0] ins, input logic v);
        check({tag, ".pc4"}, ifid_pc4, p4);
        check({tag, ".instr"}, ifid_instr, ins);
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0000_0000; imem_ready = 1'b1;
        #2;
        check("rst.pc", pc, 32'h0000_0000);
        check("rst.req", {31'd0, imem_req}, 32'd1);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        // Zero-wait streaming
        step();
        check("seq.pc4addr", pc, 32'h0000_0004);
        check_ifid("seq0", 32'h4, word_at(32'h0), 1'b1);
        step();
        check("seq.pc8", pc, 32'h0000_0008);
        check_ifid("seq1", 32'h8, word_at(32'h4), 1'b1);

        // Stall two cycles at PC=8
        stall = 1'b1;
        step();
        check("stall1.pc", pc, 32'h0000_000C);
        check("stall1.req", {31'd0, imem_req}, 32'd0);
        check_ifid("stall1", 32'h8, word_at(32'h4), 1'b1);
        step();
        check("stall2.pc", pc, 32'h0000_000C);
        check_ifid("stall2", 32'h8, word_at(32'h4), 1'b1);
        stall = 1'b0;
        step();
        check("unstall.pc", pc, 32'h0000_000C);
        check("unstall.req", {31'd0, imem_req}, 32'd1);
        check_ifid("unstall", 32'hC, word_at(32'h8), 1'b1);
        step();
        check("resume.pc", pc, 32'h0000_0010);
        check_ifid("resume", 32'h10, word_at(32'hC), 1'b1);

        // Redirect + flush at PC=0x10
        redirect = 1'b1; redirect_pc = 32'h0000_0040; flush = 1'b1;
        step();
        check("flush.pc", pc, 32'h0000_0040);
        check_ifid("flush", 32'h0, 32'h0, 1'b0);
        redirect = 1'b0; flush = 1'b0;
        step();
        check("postflush.pc", pc, 32'h0000_0044);
        check_ifid("postflush", 32'h44, word_at(32'h40), 1'b1);

        // Slow memory with redirect while waiting
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0080;
        step();
        check("drop1.addr", imem_addr, 32'h0000_0044);
        check("drop1.req", {31'd0, imem_req}, 32'd1);
        check_ifid("drop1", 32'h44, word_at(32'h40), 1'b1);
        redirect = 1'b0;
        step();
        check("drop2.addr", imem_addr, 32'h0000_0044);
        imem_ready = 1'b1;
        step();
        check("drop3.pc", pc, 32'h0000_0080);
        check_ifid("drop3", 32'h44, word_at(32'h40), 1'b1);
        step();
        check("drop4.pc", pc, 32'h0000_0084);
        check_ifid("drop4", 32'h84, word_at(32'h80), 1'b1);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap1.pc", pc, 32'hFFFF_FFFC);
        check_ifid("wrap1", 32'h84, word_at(32'h80), 1'b1);
        redirect = 1'b0;
        step();
        check("wrap2.pc", pc, 32'h0000_0000);
        check_ifid("wrap2", 32'h0, word_at(32'hFFFF_FFFC), 1'b1);

        // Asynchronous reset mid-request at PC=0x20
        redirect = 1'b1; redirect_pc = 32'h0000_0020;
        step();
        redirect = 1'b0; imem_ready = 1'b0;
        step();
        check("pre_rst.pc", pc, 32'h0000_0020);
        rst = 1'b1;
        #1;
        check("arst.pc", pc, 32'h0000_0000);
        check("arst.addr", imem_addr, 32'h0000_0000);
        check("arst.req", {31'd0, imem_req}, 32'd1);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        #1;
        rst = 1'b0; imem_ready = 1'b1;
        step();
        check("post_rst.pc", pc, 32'h0000_0004);
        check_ifid("post_rst", 32'h4, word_at(32'h0), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
